crank_cam_gen: RTL and testbench

- Parametrised trigger-wheel generator that produces the crank VR-style tooth signal and N cam-phase channels.
- Supports any teeth-total/missing-teeth pattern, runtime tooth period and prescaler, and per-channel cam windows with revolution selection.
- Drives hwag vr_in and cam inputs, either in benches or on-FPGA as a closed-loop self-test source.
- Replaces the hard-coded 60-2 stimulus process with one synthesizable block.

---
 rtl/crank_cam_gen_pkg.sv | 14 +
 rtl/crank_cam_win.sv | 22 ++
 rtl/crank_cam_gen.sv | 143 ++++++++++++++
 tb/tb_crank_cam_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/crank_cam_gen_pkg.sv
// Shared types and constants for the crank/cam trigger-wheel generator.
package crank_cam_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PERIOD_MIN        = 2;
  localparam int DEF_TEETH_TOTAL   = 60;
  localparam int DEF_TEETH_MISSING = 2;
  localparam int DEF_START_SLOT    = 45;

endpackage

// File: rtl/crank_cam_win.sv
// Single cam channel window: active inside [on, off), with wrap windows spilling into the next rev.
module crank_cam_win #(
  parameter int SLOT_W = 6
) (
  input  logic [SLOT_W-1:0] on,
  input  logic [SLOT_W-1:0] off,
  input  logic              rev_sel,
  input  logic [SLOT_W-1:0] slot,
  input  logic              rev,
  output logic              active
);

  always_comb begin
    active = 1'b0;
    if (on < off)
      active = (rev == rev_sel) && (slot >= on) && (slot < off);
    else if (on > off)
      // tail after the wrap belongs to the following revolution
      active = ((rev == rev_sel) && (slot >= on)) || ((rev != rev_sel) && (slot < off));
  end

endmodule

// File: rtl/crank_cam_gen.sv
// Crank tooth (vr) and cam-phase generator for a TEETH_TOTAL-TEETH_MISSING trigger wheel.
// Optional macro CRANK_CAM_GEN_RAMP_EN adds per-revolution period ramping.
module crank_cam_gen
  import crank_cam_gen_pkg::*;
#(
  parameter  int TEETH_TOTAL   = DEF_TEETH_TOTAL,
  parameter  int TEETH_MISSING = DEF_TEETH_MISSING,
  parameter  int START_SLOT    = DEF_START_SLOT,
  parameter  int PRESC_W       = 8,
  parameter  int PER_W         = 16,
  parameter  int CAM_CH        = 2,
  localparam int SLOT_W        = $clog2(TEETH_TOTAL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PRESC_W-1:0]       presc_top,
  input  logic [PER_W-1:0]         period,
  input  logic [CAM_CH*SLOT_W-1:0] cam_on,
  input  logic [CAM_CH*SLOT_W-1:0] cam_off,
  input  logic [CAM_CH-1:0]        cam_rev,
`ifdef CRANK_CAM_GEN_RAMP_EN
  input  logic signed [PER_W-1:0]  ramp_step,
  input  logic [PER_W-1:0]         per_min,
  input  logic [PER_W-1:0]         per_max,
`endif
  output logic                     vr,
  output logic [CAM_CH-1:0]        cam,
  output logic [SLOT_W-1:0]        slot,
  output logic                     rev,
  output logic                     sync,
  output logic                     running
);

  localparam int REAL_SLOTS = TEETH_TOTAL - TEETH_MISSING;

  state_e              state, state_nx;
  logic [PRESC_W-1:0]  pcnt, pcnt_nx;
  logic [PER_W-1:0]    tcnt, tcnt_nx, shadow, shadow_nx, reload_raw, reload_val;
  logic [SLOT_W-1:0]   slot_nx;
  logic                rev_nx, sync_nx, vr_nx, upd;
  logic [CAM_CH-1:0]   cam_nx;

  function automatic logic [PER_W-1:0] clamp_per(input logic [PER_W-1:0] p);
    return (p < PER_W'(PERIOD_MIN)) ? PER_W'(PERIOD_MIN) : p;
  endfunction

`ifdef CRANK_CAM_GEN_RAMP_EN
  logic signed [PER_W+1:0] ramp_sum;
  assign ramp_sum = $signed({2'b00, shadow}) + $signed({{2{ramp_step[PER_W-1]}}, ramp_step});
  always_comb begin
    reload_raw = ramp_sum[PER_W-1:0];
    if (ramp_sum < $signed({2'b00, per_min}))
      reload_raw = per_min;
    else if (ramp_sum > $signed({2'b00, per_max}))
      reload_raw = per_max;
  end
`else
  assign reload_raw = period;
`endif
  assign reload_val = clamp_per(reload_raw);

  // The RUN datapath is not gated by en, so a wrap coinciding with en falling still completes.
  always_comb begin
    state_nx  = state;
    pcnt_nx   = pcnt;
    tcnt_nx   = tcnt;
    shadow_nx = shadow;
    slot_nx   = slot;
    rev_nx    = rev;
    sync_nx   = 1'b0;
    case (state)
      IDLE: if (en) begin
        state_nx  = RUN;
        shadow_nx = clamp_per(period);
      end
      RUN: begin
        if (!en) state_nx = IDLE;
        if (pcnt >= presc_top) begin
          pcnt_nx = '0;
          if (tcnt >= shadow - 1'b1) begin
            tcnt_nx = '0;
            if (slot == SLOT_W'(TEETH_TOTAL - 1)) begin
              slot_nx   = '0;
              rev_nx    = ~rev;
              sync_nx   = 1'b1;
              shadow_nx = reload_val;
            end else begin
              slot_nx = slot + 1'b1;
            end
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end else begin
          pcnt_nx = pcnt + 1'b1;
        end
      end
    endcase
  end

  assign vr_nx = (slot_nx < SLOT_W'(REAL_SLOTS)) && (tcnt_nx >= (shadow_nx >> 1));
  assign upd   = (state == RUN) || en;

  for (genvar g = 0; g < CAM_CH; g++) begin : g_cam
    crank_cam_win #(.SLOT_W(SLOT_W)) u_win (
      .on      (cam_on[g*SLOT_W +: SLOT_W]),
      .off     (cam_off[g*SLOT_W +: SLOT_W]),
      .rev_sel (cam_rev[g]),
      .slot    (slot_nx),
      .rev     (rev_nx),
      .active  (cam_nx[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pcnt   <= '0;
      tcnt   <= '0;
      shadow <= PER_W'(PERIOD_MIN);
      slot   <= SLOT_W'(START_SLOT);
      rev    <= 1'b0;
      sync   <= 1'b0;
      vr     <= 1'b0;
      cam    <= '0;
    end else begin
      state  <= state_nx;
      pcnt   <= pcnt_nx;
      tcnt   <= tcnt_nx;
      shadow <= shadow_nx;
      slot   <= slot_nx;
      rev    <= rev_nx;
      sync   <= sync_nx;
      if (upd) begin
        vr  <= vr_nx;
        cam <= cam_nx;
      end
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_crank_cam_gen.sv
// Randomised and directed bench for crank_cam_gen against a behavioural wheel model.
module tb_crank_cam_gen;
  localparam int TT = 60, TM = 2, SS = 45, PW = 8, QW = 16, CH = 2, SW = 6;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [PW-1:0]    presc_top = '0;
  logic [QW-1:0]    period = 16'd64;
  logic [CH*SW-1:0] cam_on = '0, cam_off = '0;
  logic [CH-1:0]    cam_rev = '0;
  logic             vr, rev, sync, running;
  logic [CH-1:0]    cam;
  logic [SW-1:0]    slot;
`ifdef CRANK_CAM_GEN_RAMP_EN
  logic signed [QW-1:0] ramp_step = '0;
  logic [QW-1:0]        per_min = '0, per_max = '1;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0;

  crank_cam_gen #(.TEETH_TOTAL(TT), .TEETH_MISSING(TM), .START_SLOT(SS),
                  .PRESC_W(PW), .PER_W(QW), .CAM_CH(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .presc_top(presc_top), .period(period),
    .cam_on(cam_on), .cam_off(cam_off), .cam_rev(cam_rev),
`ifdef CRANK_CAM_GEN_RAMP_EN
    .ramp_step(ramp_step), .per_min(per_min), .per_max(per_max),
`endif
    .vr(vr), .cam(cam), .slot(slot), .rev(rev), .sync(sync), .running(running));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_slot, m_rev, m_pc, m_tc, m_sh, m_run;
  bit m_vr, m_sync, m_upd;
  bit [CH-1:0] m_cam;

  // Window as an arc on the 2-revolution (720 deg) circle of TT*2 slots.
  function automatic bit in_window(int on, int off, int rs, int s, int r);
    int len, d;
    if (on == off) return 1'b0;
    len = (off - on + TT) % TT;
    d   = ((r * TT + s) - (rs * TT + on) + 2 * TT) % (2 * TT);
    return d < len;
  endfunction

  function automatic int next_period();
    int v;
`ifdef CRANK_CAM_GEN_RAMP_EN
    v = m_sh + int'(ramp_step);
    if (v < int'(per_min)) v = int'(per_min);
    else if (v > int'(per_max)) v = int'(per_max);
`else
    v = int'(period);
`endif
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_slot = SS; m_rev = 0; m_pc = 0; m_tc = 0; m_sh = 2; m_run = 0;
      m_vr = 0; m_sync = 0; m_cam = '0;
    end else begin
      m_upd  = (m_run != 0) || en;
      m_sync = 0;
      if (m_run != 0) begin
        if (m_pc >= int'(presc_top)) begin
          m_pc = 0;
          if (m_tc >= m_sh - 1) begin
            m_tc = 0;
            m_slot++;
            if (m_slot == TT) begin
              m_slot = 0; m_rev ^= 1; m_sync = 1; m_sh = next_period();
            end
          end else m_tc++;
        end else m_pc = (m_pc + 1) % (1 << PW);
        m_run = en ? 1 : 0;
      end else if (en) begin
        m_run = 1;
        m_sh  = (period < 2) ? 2 : int'(period);
      end
      if (m_upd) begin
        m_vr = (m_slot < TT - TM) && (m_tc >= m_sh / 2);
        for (int c = 0; c < CH; c++)
          m_cam[c] = in_window(int'(cam_on[c*SW +: SW]), int'(cam_off[c*SW +: SW]),
                               int'(cam_rev[c]), m_slot, m_rev);
      end
    end
  end

  always @(negedge clk) begin
    if (rst)
      check("model", {20'd0, vr, cam, slot, rev, sync, running},
            {20'd0, m_vr, m_cam, SW'(m_slot), 1'(m_rev), m_sync, 1'(m_run)});
  end

  // ---------------- directed measurement ----------------
  task automatic measure(input int chg_slot, input int chg_per,
                         output int len, output int falls, output int sp_min, output int sp_max,
                         output int gap, output int c0, output int c1, output int r);
    int t0, lastf, rise, k;
    bit pv, done;
    len = 0; falls = 0; sp_min = 1 << 30; sp_max = 0; gap = 0; c0 = 0; c1 = 0; r = -1;
    lastf = -1; rise = -1; done = 0;
    for (k = 0; k < 40000 && !sync; k++) @(negedge clk);
    if (!sync) begin check("sync_timeout", 0, 1); return; end
    r = int'(rev); t0 = cyc; pv = vr; c0 = int'(cam[0]); c1 = int'(cam[1]);
    for (k = 0; k < 40000; k++) begin
      @(negedge clk);
      if (sync) break;
      if (!done && int'(slot) == chg_slot) begin period = QW'(chg_per); done = 1; end
      c0 += int'(cam[0]); c1 += int'(cam[1]);
      if (pv && !vr) begin
        falls++;
        if (lastf >= 0) begin
          if (cyc - lastf < sp_min) sp_min = cyc - lastf;
          if (cyc - lastf > sp_max) sp_max = cyc - lastf;
        end
        lastf = cyc;
      end
      if (!pv && vr && rise < 0) rise = cyc;
      pv = vr;
    end
    if (!sync) begin check("sync_timeout", 0, 1); return; end
    len = cyc - t0;
    gap = (cyc - lastf) + (rise - t0);
  endtask

  int len, falls, spmin, spmax, gap, c0, c1, r, bad;

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_vr", vr, 0);  check("rst_cam", cam, 0);  check("rst_slot", slot, 45);
    check("rst_rev", rev, 0); check("rst_sync", sync, 0); check("rst_running", running, 0);

    presc_top = 8'd3; period = 16'd64;
    cam_on = {6'd50, 6'd4}; cam_off = {6'd10, 6'd54}; cam_rev = 2'b01;
    en = 1'b1;
    @(negedge clk); rst = 1'b1;

    // Baseline revolution (rev=1)
    measure(-1, 0, len, falls, spmin, spmax, gap, c0, c1, r);
    check("base_len", len, 15360); check("base_falls", falls, 58);
    check("base_spmin", spmin, 256); check("base_spmax", spmax, 256);
    check("base_gap", gap, 640); check("base_rev", r, 1);
    check("cam0_rev1", c0, 12800); check("cam1_wrap_rev1", c1, 2560);

`ifndef CRANK_CAM_GEN_RAMP_EN
    // period changed mid-revolution is deferred to the next sync
    measure(30, 32, len, falls, spmin, spmax, gap, c0, c1, r);
    check("chg_len_old", len, 15360); check("chg_rev", r, 0);
    check("cam0_rev0", c0, 0); check("cam1_wrap_rev0", c1, 2560);
    measure(-1, 0, len, falls, spmin, spmax, gap, c0, c1, r);
    check("p32_len", len, 7680); check("p32_falls", falls, 58);
    check("p32_sp", spmax, 128); check("p32_gap", gap, 320);
    check("p32_cam0", c0, 6400); check("p32_cam1", c1, 1280);
    presc_top = 8'd0;
    measure(30, 1, len, falls, spmin, spmax, gap, c0, c1, r);
    check("p32_fast_len", len, 1920);
    measure(-1, 0, len, falls, spmin, spmax, gap, c0, c1, r);
    check("clamp_len", len, 120); check("clamp_falls", falls, 58);
    check("clamp_spmin", spmin, 2); check("clamp_spmax", spmax, 2); check("clamp_gap", gap, 5);
    check("clamp_cam0", c0, 100); check("clamp_cam1", c1, 20);
    presc_top = 8'd1; period = 16'd8;
`endif

    // Freeze at slot 20
    for (int k = 0; k < 40000 && slot != 6'd20; k++) @(negedge clk);
    check("freeze_reach", slot, 20);
    en = 1'b0; bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (slot !== 6'd20 || vr !== 1'b0 || running !== 1'b0) bad++;
    end
    check("freeze_hold", bad, 0);
    en = 1'b1;
    cam_on[SW +: SW] = 6'd7; cam_off[SW +: SW] = 6'd7;
    bad = 0;
    repeat (2000) begin @(negedge clk); bad += int'(cam[1]); end
    check("cam_on_eq_off", bad, 0);

    // Randomised run
    repeat (10000) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) en = ~en;
      if ($urandom_range(299) == 0) begin
        presc_top = PW'($urandom_range(2));
        period    = QW'($urandom_range(6));
      end
      if ($urandom_range(199) == 0)
        for (int c = 0; c < CH; c++) begin
          cam_on[c*SW +: SW]  = SW'($urandom_range(59));
          cam_off[c*SW +: SW] = ($urandom_range(7) == 0) ? cam_on[c*SW +: SW] : SW'($urandom_range(59));
          cam_rev[c]          = 1'($urandom_range(1));
        end
    end

    // Asynchronous reset mid-run
    en = 1'b1;
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_vr", vr, 0);  check("arst_cam", cam, 0);  check("arst_slot", slot, 45);
    check("arst_rev", rev, 0); check("arst_sync", sync, 0); check("arst_running", running, 0);
    en = 1'b0;
    @(negedge clk); rst = 1'b1;

`ifdef CRANK_CAM_GEN_RAMP_EN
    presc_top = 8'd0; period = 16'd64; ramp_step = -16'sd4; per_min = 16'd40; per_max = 16'd200;
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      measure(-1, 0, len, falls, spmin, spmax, gap, c0, c1, r);
      check("ramp_len", len, ((60 - 4 * i) < 40 ? 40 : (60 - 4 * i)) * 60);
    end
`endif
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
